// File: rtl/forwarding_scoreboard.sv
// Forwarding / load-use hazard unit: tracks DEPTH post-EX write slots, raises a stall and registers per-operand bypass selects.
// Optional stall-cycle counter is built only when FWD_STATS_EN is defined; otherwise stall_cycles_o is tied to 0.
module forwarding_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int ADDR_W  = 5,
    parameter int DEPTH   = 2,
    parameter int LAT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int SEL_W   = $clog2(DEPTH + 1)
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        freeze_i,
    input  logic                        ex_valid_i,
    input  logic                        ex_wen_i,
    input  logic [ADDR_W-1:0]           ex_rd_i,
    input  logic [LAT_W-1:0]            ex_lat_i,
    input  logic [NUM_SRC*ADDR_W-1:0]   id_rs_i,
    input  logic [NUM_SRC-1:0]          id_rs_used_i,
    output logic                        stall_o,
    output logic [NUM_SRC*SEL_W-1:0]    fwd_sel_o,
    output logic [31:0]                 stall_cycles_o
);

    logic              slot_valid_reg [DEPTH];
    logic              slot_wen_reg   [DEPTH];
    logic [ADDR_W-1:0] slot_rd_reg    [DEPTH];
    logic [LAT_W-1:0]  slot_lat_reg   [DEPTH];

    logic [NUM_SRC*SEL_W-1:0] fwd_sel_reg;
    logic [NUM_SRC*SEL_W-1:0] sel_next;
    logic [NUM_SRC-1:0]       hazard_vec;
    logic [LAT_W-1:0]         ex_lat_clamped;

    // A latency beyond the tracked window is ready in the last slot.
    assign ex_lat_clamped = (int'(ex_lat_i) > DEPTH - 1) ? LAT_W'(DEPTH - 1) : ex_lat_i;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_op
        logic [ADDR_W-1:0] rs;
        logic              hit;
        int                pos;
        int                lat;
        logic              hazard;
        logic [SEL_W-1:0]  sel;

        assign rs = id_rs_i[gi*ADDR_W +: ADDR_W];

        // Scan oldest to youngest so the youngest matching producer overwrites.
        always_comb begin
            hit    = 1'b0;
            pos    = 0;
            lat    = 0;
            hazard = 1'b0;
            sel    = '0;
            for (int j = DEPTH - 1; j >= 0; j--) begin
                if (slot_valid_reg[j] && slot_wen_reg[j] &&
                    (slot_rd_reg[j] != '0) && (slot_rd_reg[j] == rs)) begin
                    hit = 1'b1;
                    pos = j + 1;
                    lat = int'(slot_lat_reg[j]);
                end
            end
            if (ex_valid_i && ex_wen_i && (ex_rd_i != '0) && (ex_rd_i == rs)) begin
                hit = 1'b1;
                pos = 0;
                lat = int'(ex_lat_clamped);
            end
            if (id_rs_used_i[gi] && hit && (pos < DEPTH)) begin
                if (lat > pos) begin
                    hazard = 1'b1;
                end else begin
                    sel = SEL_W'(pos + 1);
                end
            end
        end

        assign hazard_vec[gi]                 = hazard;
        assign sel_next[gi*SEL_W +: SEL_W]    = sel;
    end

    assign stall_o   = !rst_i && (|hazard_vec);
    assign fwd_sel_o = fwd_sel_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int j = 0; j < DEPTH; j++) begin
                slot_valid_reg[j] <= 1'b0;
                slot_wen_reg[j]   <= 1'b0;
                slot_rd_reg[j]    <= '0;
                slot_lat_reg[j]   <= '0;
            end
            fwd_sel_reg <= '0;
        end else if (!freeze_i) begin
            slot_valid_reg[0] <= ex_valid_i;
            slot_wen_reg[0]   <= ex_wen_i;
            slot_rd_reg[0]    <= ex_rd_i;
            slot_lat_reg[0]   <= ex_lat_clamped;
            for (int j = 1; j < DEPTH; j++) begin
                slot_valid_reg[j] <= slot_valid_reg[j-1];
                slot_wen_reg[j]   <= slot_wen_reg[j-1];
                slot_rd_reg[j]    <= slot_rd_reg[j-1];
                slot_lat_reg[j]   <= slot_lat_reg[j-1];
            end
            // A stalled consumer does not enter EX; EX gets a bubble instead.
            fwd_sel_reg <= stall_o ? '0 : sel_next;
        end
    end

`ifdef FWD_STATS_EN
    logic [31:0] stall_cnt_reg;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            stall_cnt_reg <= '0;
        end else if (!freeze_i && stall_o && (stall_cnt_reg != 32'hFFFF_FFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 32'd1;
        end
    end

    assign stall_cycles_o = stall_cnt_reg;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_forwarding_scoreboard.sv
// Directed bench for forwarding_scoreboard (NUM_SRC=2, DEPTH=2); expected values are hand-computed per step.
module tb_forwarding_scoreboard;

    logic        clk = 1'b0;
    logic        rst;
    logic        freeze;
    logic        ex_valid;
    logic        ex_wen;
    logic [4:0]  ex_rd;
    logic [0:0]  ex_lat;
    logic [9:0]  id_rs;
    logic [1:0]  id_used;
    logic        stall;
    logic [3:0]  fwd_sel;
    logic [31:0] stall_cycles;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    forwarding_scoreboard dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .freeze_i       (freeze),
        .ex_valid_i     (ex_valid),
        .ex_wen_i       (ex_wen),
        .ex_rd_i        (ex_rd),
        .ex_lat_i       (ex_lat),
        .id_rs_i        (id_rs),
        .id_rs_used_i   (id_used),
        .stall_o        (stall),
        .fwd_sel_o      (fwd_sel),
        .stall_cycles_o (stall_cycles)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    function automatic logic [31:0] exp_cnt(input int n);
`ifdef FWD_STATS_EN
        return 32'(n);
`else
        return 32'(0 * n);
`endif
    endfunction

    task automatic set_ex(input logic v, input logic w, input logic [4:0] rd, input logic l);
        ex_valid = v;
        ex_wen   = w;
        ex_rd    = rd;
        ex_lat   = l;
    endtask

    task automatic set_id(input logic [4:0] rs0, input logic [4:0] rs1, input logic [1:0] used);
        id_rs   = {rs1, rs0};
        id_used = used;
    endtask

    // Advance one edge, then settle so registered outputs can be sampled.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst    = 1'b1;
        freeze = 1'b0;
        set_ex(1'b1, 1'b1, 5'd7, 1'b1);
        set_id(5'd0, 5'd7, 2'b10);
        #1;
        check("reset_stall_comb", {31'd0, stall}, 32'd0);
        tick();
        tick();
        check("reset_fwd", {28'd0, fwd_sel}, 32'd0);
        check("reset_cnt", stall_cycles, 32'd0);

        rst = 1'b0;
        set_ex(1'b0, 1'b0, 5'd0, 1'b0);
        set_id(5'd0, 5'd0, 2'b00);
        tick();

        // ALU back-to-back
        set_ex(1'b1, 1'b1, 5'd5, 1'b0);
        set_id(5'd5, 5'd0, 2'b01);
        #1 check("alu_stall", {31'd0, stall}, 32'd0);
        tick();
        check("alu_fwd", {28'd0, fwd_sel}, 32'h1);

        // Load-use, one stall cycle
        set_ex(1'b1, 1'b1, 5'd7, 1'b1);
        set_id(5'd0, 5'd7, 2'b10);
        #1 check("lu_stall", {31'd0, stall}, 32'd1);
        tick();
        check("lu_fwd_bubble", {28'd0, fwd_sel}, 32'h0);
        set_ex(1'b0, 1'b0, 5'd0, 1'b0);
        #1 check("lu_release", {31'd0, stall}, 32'd0);
        tick();
        check("lu_fwd", {28'd0, fwd_sel}, 32'h8);
        check("lu_cnt", stall_cycles, exp_cnt(1));

        // Priority: youngest producer wins
        set_ex(1'b1, 1'b1, 5'd3, 1'b0);
        set_id(5'd0, 5'd0, 2'b00);
        tick();
        set_ex(1'b1, 1'b1, 5'd3, 1'b0);
        set_id(5'd3, 5'd3, 2'b11);
        #1 check("prio_stall", {31'd0, stall}, 32'd0);
        tick();
        check("prio_ex_fwd", {28'd0, fwd_sel}, 32'h5);
        set_ex(1'b1, 1'b1, 5'd3, 1'b1);
        #1 check("prio_ex_load_stall", {31'd0, stall}, 32'd1);
        tick();
        check("prio_ex_load_fwd", {28'd0, fwd_sel}, 32'h0);
        set_ex(1'b1, 1'b0, 5'd3, 1'b0);
        #1 check("prio_nowen_stall", {31'd0, stall}, 32'd0);
        tick();
        check("prio_slot_fwd", {28'd0, fwd_sel}, 32'hA);

        // x0 never matches
        set_ex(1'b1, 1'b1, 5'd0, 1'b0);
        set_id(5'd0, 5'd0, 2'b11);
        #1 check("x0_stall", {31'd0, stall}, 32'd0);
        tick();
        check("x0_fwd", {28'd0, fwd_sel}, 32'h0);

        // Unused operand never stalls
        set_ex(1'b1, 1'b1, 5'd9, 1'b1);
        set_id(5'd0, 5'd9, 2'b01);
        #1 check("unused_stall", {31'd0, stall}, 32'd0);
        id_used = 2'b10;
        #1 check("used_stall", {31'd0, stall}, 32'd1);
        id_used = 2'b01;
        #1 tick();
        check("unused_fwd", {28'd0, fwd_sel}, 32'h0);

        // Freeze during a pending load-use
        set_ex(1'b1, 1'b1, 5'd4, 1'b0);
        set_id(5'd4, 5'd0, 2'b01);
        tick();
        check("pre_freeze_fwd", {28'd0, fwd_sel}, 32'h1);
        freeze = 1'b1;
        set_ex(1'b1, 1'b1, 5'd7, 1'b1);
        set_id(5'd0, 5'd7, 2'b10);
        for (int i = 0; i < 3; i++) begin
            #1 check($sformatf("frz_stall_%0d", i), {31'd0, stall}, 32'd1);
            tick();
            check($sformatf("frz_fwd_%0d", i), {28'd0, fwd_sel}, 32'h1);
            check($sformatf("frz_cnt_%0d", i), stall_cycles, exp_cnt(2));
        end
        freeze = 1'b0;
        #1 check("frz_rel_stall", {31'd0, stall}, 32'd1);
        tick();
        check("frz_rel_fwd", {28'd0, fwd_sel}, 32'h0);
        set_ex(1'b0, 1'b0, 5'd0, 1'b0);
        #1 check("frz_res_stall", {31'd0, stall}, 32'd0);
        tick();
        check("frz_res_fwd", {28'd0, fwd_sel}, 32'h8);
        check("frz_cnt", stall_cycles, exp_cnt(3));

        // Reset mid-stall
        set_ex(1'b1, 1'b1, 5'd7, 1'b1);
        set_id(5'd0, 5'd7, 2'b10);
        #1 check("rst_pre_stall", {31'd0, stall}, 32'd1);
        rst = 1'b1;
        #1 check("rst_stall_comb", {31'd0, stall}, 32'd0);
        tick();
        check("rst_fwd", {28'd0, fwd_sel}, 32'h0);
        check("rst_cnt", stall_cycles, 32'd0);
        rst = 1'b0;
        set_ex(1'b0, 1'b0, 5'd0, 1'b0);
        #1 check("rst_no_stale_stall", {31'd0, stall}, 32'd0);
        tick();
        check("rst_no_stale_fwd", {28'd0, fwd_sel}, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/forwarding_scoreboard.md
# forwarding_scoreboard

Parametrised forwarding and load-use hazard unit for the in-order RISC-V pipeline. It tracks in-flight register writes over a configurable number of post-EX stages, checks the ID-stage operands against them, and raises a stall when a producer's result will not be ready in time. When no stall is needed, it registers per-operand bypass selects that are valid while the instruction sits in EX. It generalises fixed two-stage (MEM/WB) forwarding to N source operands, DEPTH tracked stages and per-instruction result latency.

## Interface
- NUM_SRC, 2, source operands per instruction
- ADDR_W, 5, register address width
- DEPTH, 2, post-EX stages tracked (slot 0 = MEM, slot DEPTH-1 = last stage before register-file write)
- LAT_W, $clog2(DEPTH) (min 1), width of latency field
- SEL_W, $clog2(DEPTH+1), width of one bypass select

- clk_i  in  1  clock, the single clock; all state changes on its rising edge
- rst_i  in  1  reset, synchronous, active-high
- freeze_i  in  1  global pipeline hold (e.g. memory miss)
- ex_valid_i  in  1  EX holds a real instruction (0 = bubble/flushed)
- ex_wen_i  in  1  EX instruction writes rd
- ex_rd_i  in  ADDR_W  EX destination register
- ex_lat_i  in  LAT_W  result latency: data forwardable from slot ex_lat_i onward (0 = ALU, 1 = load)
- id_rs_i  in  NUM_SRC*ADDR_W  ID source registers, operand k at bits [k*ADDR_W +: ADDR_W]
- id_rs_used_i  in  NUM_SRC  operand k actually read
- stall_o  out  1  load-use hazard: hold IF/ID, inject bubble into EX
- fwd_sel_o  out  NUM_SRC*SEL_W  per-operand bypass for the EX instruction: 0 = register file, s = slot s-1
- stall_cycles_o  out  32  stall cycle count (see Configuration)

## Operation
- Slot array: DEPTH entries of {valid, wen, rd, lat}.
- Advance: the array advances every cycle in which freeze_i=0. A stall does not block the advance.
  - Slot 0 takes the EX inputs.
  - Slot k takes slot k-1.
  - The entry in slot DEPTH-1 retires.
- The register file is write-before-read, so a retired write is visible to ID.
- Producers of each used operand k, checked in age order, youngest first: EX inputs, then slot 0 up to slot DEPTH-1.
  - A producer matches if valid & wen & rd!=0 & rd==id_rs[k].
  - Only the youngest match is considered.
- Position next cycle, p: EX producer → 0; slot j → j+1.
- Outcome for operand k:
  - No match, or p ≥ DEPTH → select 0.
  - lat > p → hazard.
  - Otherwise → select p+1.
- stall_o is the OR of hazards over used operands, is combinational from current state and inputs, and is forced to 0 while rst_i=1.
- fwd_sel_o update on each advancing cycle:
  - stall_o=0 → computed selects.
  - stall_o=1 → all zeros, since EX receives a bubble.
- While freeze_i=1: slots, fwd_sel_o and the counter hold; stall_o is still evaluated.
- Unused operands (id_rs_used_i[k]=0): never stall, select 0.
- ex_lat_i values ≥ DEPTH are treated as DEPTH-1.

## Timing
- Reset (rst_i=1 at an edge):
  - all slots invalid
  - fwd_sel_o = 0
  - stall_cycles_o = 0
  - stall_o = 0 combinationally while asserted
- Reset has priority over freeze_i and over an in-progress stall.
- Hazard-to-stall latency: 0 cycles, combinational.
- Select latency: 1 cycle, registered on the edge the ID instruction enters EX.
- Load-use with DEPTH=2, lat=1, consumer directly behind: exactly one stall cycle. lat=L with distance 1 stalls L cycles.
- Simultaneous match in EX and slots: the EX (youngest) entry wins even if it causes a stall.
- rd=0 never matches, even with wen=1.

## Configuration
- FWD_STATS_EN defined: stall_cycles_o is a 32-bit counter.
  - Increments on each edge with stall_o=1, freeze_i=0, rst_i=0.
  - Saturates at 0xFFFFFFFF.
  - Cleared by reset.
- Undefined: stall_cycles_o is tied to 0 and no counter is built.

## Test plan
(NUM_SRC=2, DEPTH=2)
- ALU back-to-back: EX {valid, wen, rd=5, lat=0}, ID rs0=5 used → stall_o=0; next cycle fwd_sel_o[op0]=1.
- Load-use: EX {rd=7, lat=1}, ID rs1=7 used →
  - stall_o=1 for one cycle, next fwd_sel_o=0;
  - then with ex_valid_i=0: stall_o=0;
  - next cycle fwd_sel_o[op1]=2.
  - stall_cycles_o=1 with FWD_STATS_EN.
- Priority: slot 0 holds rd=3, EX also rd=3 lat=0, ID rs0=rs1=3 → both selects 1 next cycle. With a wen=0 EX producer → both selects 2.
- x0 and unused operand: EX rd=0 wen=1, ID rs0=0 → select 0. EX rd=9 lat=1 with id_rs_used_i[1]=0 and rs1=9 → stall_o=0.
- Freeze: freeze_i=1 for 3 cycles during a pending load-use → slots, fwd_sel_o and counter unchanged; after release the stall resolves as in the load-use case.
- Reset mid-stall: assert rst_i while a hazard is pending → stall_o=0 immediately; after the edge all selects and the counter are 0 and no stale slot matches.
